dmem_access_ctrl: RTL and testbench

// - MEM-stage data-memory access controller for the 5-stage pipeline; drives a valid/ready bus to a multi-cycle data memory.
// - Requester side of the stall protocol: raises stall_mem while a load/store is outstanding; the hazard unit consumes it to freeze IF/ID/EX/MEM.
// - Generates byte enables and aligned write data; sign/zero-extends load data; flags misaligned accesses and bus timeouts.

---
 rtl/dmem_access_ctrl_pkg.sv | 32 +++
 rtl/dmem_access_ctrl_lsu_align.sv | 53 +++++
 rtl/dmem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// funct3 access codes, FSM states and the alignment check.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  // Unknown funct3 codes are treated as misaligned so they never reach the bus.
  function automatic logic is_aligned(input logic [2:0] f3,
                                      input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lsu_align.sv
// Lane steering for the data-memory controller: byte enables,
// replicated store data and sign/zero-extended load data.
module lsu_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        rdata_o = {{24{lane[7]}}, lane[7:0]};
      end
      F3_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        rdata_o = {24'h0, lane[7:0]};
      end
      F3_H: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{sdata_i[15:0]}};
        rdata_o = {{16{lane[15]}}, lane[15:0]};
      end
      F3_HU: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{sdata_i[15:0]}};
        rdata_o = {16'h0, lane[15:0]};
      end
      F3_W: begin
        be_o    = 4'hF;
        wdata_o = sdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: valid/ready bus requester
// that stalls the pipeline while a load or store is outstanding.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_mem,
  input  logic        mem_we_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_ans_mem,
  input  logic [31:0] rf_rd1_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall_mem,
  output logic [31:0] dmem_rd_mem,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [7:0] LIM = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdat_q, sdat_d;
  logic [31:0] rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        access, aligned, go, timeout;
  logic [3:0]  be;
  logic [31:0] wdata, rext;

  assign access  = mem_re_mem | mem_we_mem;
  assign aligned = is_aligned(funct3_mem, alu_ans_mem[1:0]);
  assign go      = (state_q == S_IDLE) & access & aligned;

  // Counter covers REQ and WAIT together; progress beats expiry.
  assign timeout = (cnt_q >= LIM) &
                   (((state_q == S_REQ) & ~bus_ready) |
                    ((state_q == S_WAIT) & ~bus_rvalid));

  lsu_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .sdata_i  (sdat_q),
    .rdata_i  (bus_rdata),
    .be_o     (be),
    .wdata_o  (wdata),
    .rdata_o  (rext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_REQ;
      S_REQ: begin
        if (bus_ready)    state_d = we_q ? S_DONE : S_WAIT;
        else if (timeout) state_d = S_DONE;
      end
      S_WAIT: if (bus_rvalid | timeout) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = 32'h0;
    bus_be       = 4'b0000;
    bus_wdata    = 32'h0;
    stall_mem    = 1'b0;
    misalign_err = 1'b0;
    dmem_rd_mem  = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        stall_mem    = go;
        misalign_err = access & ~aligned;
      end
      S_REQ: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be;
        bus_wdata = wdata;
        stall_mem = 1'b1;
      end
      S_WAIT: stall_mem = 1'b1;
      S_DONE: dmem_rd_mem = rd_q;
      default: ;
    endcase
  end

  assign bus_err = err_q;

  always_comb begin
    addr_d = addr_q;
    sdat_d = sdat_q;
    f3_d   = f3_q;
    we_d   = we_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = timeout;
    if (go) begin
      addr_d = alu_ans_mem;
      sdat_d = rf_rd1_mem;
      f3_d   = funct3_mem;
      we_d   = mem_we_mem;
      rd_d   = 32'h0;
      cnt_d  = 8'h0;
    end else if ((state_q == S_REQ) | (state_q == S_WAIT)) begin
      cnt_d = cnt_q + 8'h1;
      if ((state_q == S_WAIT) & bus_rvalid) rd_d = rext;
      else if (timeout)                     rd_d = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 32'h0;
      sdat_q <= 32'h0;
      f3_q   <= 3'b000;
      we_q   <= 1'b0;
      rd_q   <= 32'h0;
      cnt_q  <= 8'h0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      sdat_q <= sdat_d;
      f3_q   <= f3_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table driven through a bus
// responder, with expected results queued at issue and checked at completion.
module tb_dmem_access_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        mis;
    logic        berr;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    logic        berr;
    logic        mis;
    int          stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re_mem, mem_we_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_ans_mem, rf_rd1_mem;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall_mem;
  logic [31:0] dmem_rd_mem;
  logic        misalign_err, bus_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[16];

  dmem_access_ctrl #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_re_mem   (mem_re_mem),
    .mem_we_mem   (mem_we_mem),
    .funct3_mem   (funct3_mem),
    .alu_ans_mem  (alu_ans_mem),
    .rf_rd1_mem   (rf_rd1_mem),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ready    (bus_ready),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .stall_mem    (stall_mem),
    .dmem_rd_mem  (dmem_rd_mem),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e, h;
    int   stalls, reqn, waitn;
    bit   acc, acc_now, seen, done;
    stalls = 0; reqn = 0; waitn = 0;
    acc = 0; seen = 0; done = 0;
    @(posedge clk); #1;
    mem_re_mem  = ~v.we;
    mem_we_mem  = v.we;
    funct3_mem  = v.f3;
    alu_ans_mem = v.addr;
    rf_rd1_mem  = v.sdata;
    bus_rdata   = v.rdata;
    e.waddr  = {v.addr[31:2], 2'b00};
    e.be     = v.be;
    e.wdata  = v.wdata;
    e.we     = v.we;
    e.rd     = v.rd;
    e.berr   = v.berr;
    e.mis    = v.mis;
    e.stalls = v.stalls;
    sb.push_back(e);
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (v.mis) begin
        h = sb.pop_front();
        chk($sformatf("v%0d misalign_err", idx), 32'(misalign_err), 32'(h.mis));
        chk($sformatf("v%0d mis_stall", idx), 32'(stall_mem), 32'(0));
        chk($sformatf("v%0d mis_req", idx), 32'(bus_req), 32'(0));
        chk($sformatf("v%0d mis_rd", idx), dmem_rd_mem, h.rd);
        mem_re_mem = 1'b0;
        mem_we_mem = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d mis_pulse", idx), 32'(misalign_err), 32'(0));
        chk($sformatf("v%0d mis_req2", idx), 32'(bus_req), 32'(0));
        done = 1;
      end else if (cyc > 0 && !stall_mem) begin
        h = sb.pop_front();
        chk($sformatf("v%0d rd", idx), dmem_rd_mem, h.rd);
        chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(h.berr));
        chk($sformatf("v%0d stalls", idx), 32'(stalls), 32'(h.stalls));
        chk($sformatf("v%0d done_req", idx), 32'(bus_req), 32'(0));
        mem_re_mem = 1'b0;
        mem_we_mem = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        done = 1;
      end else begin
        if (stall_mem) stalls++;
        if (bus_req) begin
          if (!seen) begin
            chk($sformatf("v%0d addr", idx), bus_addr, sb[0].waddr);
            chk($sformatf("v%0d be", idx), 32'(bus_be), 32'(sb[0].be));
            chk($sformatf("v%0d wdata", idx), bus_wdata, sb[0].wdata);
            chk($sformatf("v%0d we", idx), 32'(bus_we), 32'(sb[0].we));
            seen = 1;
          end
          bus_ready = (reqn == v.rdy);
          reqn++;
        end else begin
          bus_ready = 1'b0;
        end
        if (acc && !v.we && stall_mem && !bus_req) begin
          bus_rvalid = (waitn == v.rv);
          waitn++;
        end else begin
          bus_rvalid = 1'b0;
        end
        acc_now = bus_req && bus_ready;
        @(posedge clk);
        acc = acc | acc_now;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d completion: got none want done within 60 cycles", idx);
      if (sb.size() > 0) void'(sb.pop_front());
      mem_re_mem = 1'b0;
      mem_we_mem = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_re_mem = 1'b0; mem_we_mem = 1'b0;
    funct3_mem = 3'b000; alu_ans_mem = 32'h0; rf_rd1_mem = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    // we, f3, addr, sdata, rdata, rdy, rv, be, wdata, rd, mis, berr, stalls
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
                 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF00, 1, 1,
                 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF00, 1, 1,
                 4'b1000, 32'h0, 32'h00000080, 1'b0, 1'b0, 5};
    vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h12345678, 0, 0,
                 4'b1100, 32'h0, 32'h00001234, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h12345678, 0, 0,
                 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 2, 0,
                 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 4};
    vecs[7]  = '{1'b1, 3'b001, 32'h206, 32'hCAFEBEEF, 32'h0, 0, 0,
                 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0, 2};
    vecs[8]  = '{1'b0, 3'b101, 32'h106, 32'h0, 32'h80017FFF, 0, 2,
                 4'b1100, 32'h0, 32'h00008001, 1'b0, 1'b0, 5};
    vecs[9]  = '{1'b0, 3'b001, 32'h106, 32'h0, 32'h80017FFF, 0, 0,
                 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 3'b000, 32'h100, 32'h0, 32'h1234567F, 0, 0,
                 4'b0001, 32'h0, 32'h0000007F, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 3'b010, 32'h108, 32'h0, 32'h11111111, 99, 0,
                 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 5};
    vecs[12] = '{1'b0, 3'b010, 32'h10C, 32'h0, 32'h22222222, 0, 99,
                 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 5};
    vecs[13] = '{1'b1, 3'b010, 32'h102, 32'h55555555, 32'h0, 0, 0,
                 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 0};
    vecs[14] = '{1'b1, 3'b010, 32'h000, 32'h12345678, 32'h0, 3, 0,
                 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0, 5};
    vecs[15] = '{1'b0, 3'b010, 32'h010, 32'h0, 32'h0BADF00D, 3, 0,
                 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 6};

    repeat (2) @(posedge clk);
    #1;
    chk("rst bus_req", 32'(bus_req), 32'(0));
    chk("rst bus_we", 32'(bus_we), 32'(0));
    chk("rst stall", 32'(stall_mem), 32'(0));
    chk("rst addr", bus_addr, 32'h0);
    chk("rst be", 32'(bus_be), 32'(0));
    chk("rst wdata", bus_wdata, 32'h0);
    chk("rst rd", dmem_rd_mem, 32'h0);
    chk("rst mis", 32'(misalign_err), 32'(0));
    chk("rst berr", 32'(bus_err), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run(vecs[i], i);

    // Reset while a load waits for read data, then a stray rvalid.
    @(posedge clk); #1;
    mem_re_mem  = 1'b1;
    funct3_mem  = 3'b010;
    alu_ans_mem = 32'h110;
    #1;
    chk("rw idle stall", 32'(stall_mem), 32'(1));
    @(posedge clk); #1;
    chk("rw req", 32'(bus_req), 32'(1));
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("rw wait stall", 32'(stall_mem), 32'(1));
    chk("rw wait req", 32'(bus_req), 32'(0));
    rst = 1'b1;
    mem_re_mem = 1'b0;
    #1;
    chk("rw async stall", 32'(stall_mem), 32'(0));
    chk("rw async req", 32'(bus_req), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rdata  = 32'hFFFFFFFF;
    bus_rvalid = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rw post stall", 32'(stall_mem), 32'(0));
      chk("rw post req", 32'(bus_req), 32'(0));
      chk("rw post rd", dmem_rd_mem, 32'h0);
      chk("rw post berr", 32'(bus_err), 32'(0));
      chk("rw post be", 32'(bus_be), 32'(0));
      chk("rw post addr", bus_addr, 32'h0);
      @(posedge clk); #1;
    end

    run(vecs[0], 100);
    run(vecs[4], 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
